// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode/funct encodings and FSM state type for the ID/EX hazard and stall controller.
package pipeline_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/hazard_instr_decode.sv
// Combinational decode of the IF/ID instruction: register fields, which source
// registers it reads, and whether it is a multiply/divide or an HI/LO move.
module hazard_instr_decode
    import pipeline_ctrl_pkg::*;
(
    input  logic [31:0] id_instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        is_mdu,
    output logic        is_hilo
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_nop;
    logic       is_rtype;

    always_comb begin
        op       = id_instr[31:26];
        funct    = id_instr[5:0];
        rs       = id_instr[25:21];
        rt       = id_instr[20:16];
        is_nop   = (id_instr == 32'h0);
        is_rtype = (op == OP_RTYPE) && !is_nop;

        // Shifts by immediate read rt only; jumps read no registers.
        uses_rs = !(is_nop || op == OP_J || op == OP_JAL ||
                    (op == OP_RTYPE && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)));
        uses_rt = is_rtype || op == OP_BEQ || op == OP_BNE || op == OP_SW;

        is_mdu  = (op == OP_RTYPE) && (funct == FN_MULT || funct == FN_MULTU ||
                                       funct == FN_DIV  || funct == FN_DIVU);
        is_hilo = (op == OP_RTYPE) && (funct == FN_MFHI || funct == FN_MFLO);
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// ID/EX sequencing controller: load-use stalls, MDU occupancy window, branch flush.
// Optional stall-cycle statistic counter built only when HAZARD_STATS_EN is defined.
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cycles
);

    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_mdu;
    logic       is_hilo;
    logic       load_use;
    logic       stall;
    logic       start_raw;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    hazard_instr_decode u_decode (
        .id_instr (id_instr),
        .rs       (rs),
        .rt       (rt),
        .uses_rs  (uses_rs),
        .uses_rt  (uses_rt),
        .is_mdu   (is_mdu),
        .is_hilo  (is_hilo)
    );

    always_comb begin
        load_use = idex_mem_read && (idex_rt != 5'd0) &&
                   ((uses_rs && rs == idex_rt) || (uses_rt && rt == idex_rt));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        start_raw = 1'b0;
        mdu_busy  = 1'b0;
        mdu_done  = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall = load_use;
                if (is_mdu && !load_use) begin
                    start_raw = 1'b1;
                    cnt_d     = CNT_W'(MDU_CYCLES - 1);
                    state_d   = ST_MDU_BUSY;
                end
            end
            ST_MDU_BUSY: begin
                mdu_busy = 1'b1;
                stall    = load_use || is_hilo || is_mdu;
                if (cnt_q == '0) begin
                    mdu_done = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State is forced to RUN asynchronously in reset, so only the input-driven
    // terms need masking to keep the outputs at their reset values.
    always_comb begin
        pc_write    = !(stall && rst_n);
        ifid_write  = !(stall && rst_n);
        idex_bubble = stall && rst_n;
        ifid_flush  = branch_taken && !stall && rst_n;
        mdu_start   = start_raw && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_write && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with a 4-cycle MDU window.
// Stall statistic expectations follow whether HAZARD_STATS_EN is defined.
module tb_hazard_stall_controller;

    localparam int MDU_CYCLES = 4;
    localparam logic [31:0] I_NOP    = 32'h0000_0000;
    localparam logic [31:0] I_ADD    = 32'h0233_8020; // add  $s0,$s1,$s3
    localparam logic [31:0] I_ADD0   = 32'h0000_4020; // add  $t0,$zero,$zero
    localparam logic [31:0] I_SLL    = 32'h0011_4880; // sll  $t1,$s1,2
    localparam logic [31:0] I_J      = 32'h0A20_0000; // j with rs bits = 17
    localparam logic [31:0] I_SW     = 32'hAD11_0000; // sw   $s1,0($t0)
    localparam logic [31:0] I_LW     = 32'h8D11_0000; // lw   $s1,0($t0)
    localparam logic [31:0] I_MULT   = 32'h0232_0018; // mult $s1,$s2
    localparam logic [31:0] I_MFLO   = 32'h0000_4012; // mflo $t0

    // {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_start, mdu_busy, mdu_done}
    localparam logic [6:0] V_IDLE  = 7'b1100000;
    localparam logic [6:0] V_STALL = 7'b0001000;
    localparam logic [6:0] V_FLUSH = 7'b1110000;
    localparam logic [6:0] V_START = 7'b1100100;
    localparam logic [6:0] V_BUSY  = 7'b1100010;
    localparam logic [6:0] V_BSTL  = 7'b0001010;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;
    logic        branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        mdu_start;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] stall_cycles;
    logic [6:0]  out_vec;

    int checks;
    int errors;

    hazard_stall_controller #(
        .MDU_CYCLES (MDU_CYCLES),
        .CNT_W      (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_instr      (id_instr),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .mdu_start     (mdu_start),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .stall_cycles  (stall_cycles)
    );

    assign out_vec = {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_start, mdu_busy, mdu_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge, then apply inputs.
    task automatic step(input logic [31:0] instr, input logic mr, input logic [4:0] rt, input logic br);
        @(posedge clk);
        #1;
        id_instr      = instr;
        idex_mem_read = mr;
        idex_rt       = rt;
        branch_taken  = br;
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_instr = I_NOP; idex_mem_read = 1'b0; idex_rt = 5'd0; branch_taken = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_instr = I_MULT; idex_mem_read = 1'b1; idex_rt = 5'd17; branch_taken = 1'b1;
        #2;
        checks++;
        if (out_vec !== V_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", out_vec, V_IDLE);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d expected 0", stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        step(I_ADD, 1'b1, 5'd17, 1'b0);
        checks++;
        if (out_vec !== V_STALL) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected %b", out_vec, V_STALL);
        end
        step(I_ADD, 1'b0, 5'd0, 1'b0);
        checks++;
        if (out_vec !== V_IDLE) begin
            errors++;
            $display("FAIL load_use_release: got %b expected %b", out_vec, V_IDLE);
        end
        step(I_SW, 1'b1, 5'd17, 1'b0);
        checks++;
        if (out_vec !== V_STALL) begin
            errors++;
            $display("FAIL load_use_sw_rt: got %b expected %b", out_vec, V_STALL);
        end
    endtask

    task automatic test_no_false_hazard();
        logic [31:0] instrs [4];
        logic [4:0]  rts [4];
        instrs = '{I_ADD0, I_SLL, I_J, I_LW};
        rts    = '{5'd0, 5'd0, 5'd17, 5'd17};
        for (int i = 0; i < 4; i++) begin
            step(instrs[i], 1'b1, rts[i], 1'b0);
            checks++;
            if (out_vec !== V_IDLE) begin
                errors++;
                $display("FAIL no_false_hazard[%0d]: got %b expected %b", i, out_vec, V_IDLE);
            end
        end
    endtask

    task automatic test_branch();
        step(I_ADD, 1'b0, 5'd0, 1'b1);
        checks++;
        if (out_vec !== V_FLUSH) begin
            errors++;
            $display("FAIL branch_flush: got %b expected %b", out_vec, V_FLUSH);
        end
        step(I_ADD, 1'b1, 5'd19, 1'b1);
        checks++;
        if (out_vec !== V_STALL) begin
            errors++;
            $display("FAIL branch_vs_stall: got %b expected %b", out_vec, V_STALL);
        end
    endtask

    task automatic test_mdu_window();
        logic [6:0] exp_v;
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        checks++;
        if (out_vec !== V_START) begin
            errors++;
            $display("FAIL mdu_issue: got %b expected %b", out_vec, V_START);
        end
        for (int k = 1; k <= MDU_CYCLES; k++) begin
            step(I_MFLO, 1'b0, 5'd0, 1'b0);
            exp_v = (k == MDU_CYCLES) ? (V_BSTL | 7'b0000001) : V_BSTL;
            checks++;
            if (out_vec !== exp_v) begin
                errors++;
                $display("FAIL mdu_mflo_stall[T+%0d]: got %b expected %b", k, out_vec, exp_v);
            end
        end
        step(I_MFLO, 1'b0, 5'd0, 1'b0);
        checks++;
        if (out_vec !== V_IDLE) begin
            errors++;
            $display("FAIL mdu_mflo_proceed: got %b expected %b", out_vec, V_IDLE);
        end
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        for (int k = 1; k <= MDU_CYCLES; k++) begin
            step(I_ADD, 1'b0, 5'd0, 1'b0);
            exp_v = (k == MDU_CYCLES) ? (V_BUSY | 7'b0000001) : V_BUSY;
            checks++;
            if (out_vec !== exp_v) begin
                errors++;
                $display("FAIL mdu_unrelated_add[T+%0d]: got %b expected %b", k, out_vec, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        for (int k = 1; k <= MDU_CYCLES; k++) begin
            step(I_MULT, 1'b0, 5'd0, 1'b0);
            checks++;
            if (mdu_start !== 1'b0 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL b2b_mult_held[T+%0d]: start=%b pc_write=%b expected start=0 pc_write=0",
                         k, mdu_start, pc_write);
            end
        end
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        checks++;
        if (out_vec !== V_START) begin
            errors++;
            $display("FAIL b2b_mult_reissue: got %b expected %b", out_vec, V_START);
        end
        for (int k = 1; k <= MDU_CYCLES; k++) step(I_NOP, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_reset_mid_window();
        int saw_done;
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        step(I_NOP, 1'b0, 5'd0, 1'b0);
        step(I_MFLO, 1'b1, 5'd17, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vec !== V_IDLE || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_window: got %b stats=%0d expected %b stats=0",
                     out_vec, stall_cycles, V_IDLE);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        saw_done = 0;
        for (int k = 0; k < MDU_CYCLES + 2; k++) begin
            step(I_MFLO, 1'b0, 5'd0, 1'b0);
            if (mdu_done !== 1'b0 || mdu_busy !== 1'b0 || pc_write !== 1'b1) saw_done++;
        end
        checks++;
        if (saw_done !== 0) begin
            errors++;
            $display("FAIL reset_abort_window: got %0d busy/done/stall cycles expected 0", saw_done);
        end
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        checks++;
        if (out_vec !== V_START) begin
            errors++;
            $display("FAIL reset_new_mult: got %b expected %b", out_vec, V_START);
        end
        for (int k = 1; k <= MDU_CYCLES; k++) step(I_NOP, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_stats();
        logic [31:0] exp_stats;
`ifdef HAZARD_STATS_EN
        exp_stats = 32'd4;
`else
        exp_stats = 32'd0;
`endif
        do_reset();
        step(I_ADD, 1'b1, 5'd17, 1'b0);
        step(I_ADD, 1'b0, 5'd0, 1'b0);
        step(I_MULT, 1'b0, 5'd0, 1'b0);
        step(I_ADD, 1'b0, 5'd0, 1'b0);
        for (int k = 2; k <= MDU_CYCLES; k++) step(I_MFLO, 1'b0, 5'd0, 1'b0);
        step(I_MFLO, 1'b0, 5'd0, 1'b0);
        checks++;
        if (stall_cycles !== exp_stats || out_vec !== V_IDLE) begin
            errors++;
            $display("FAIL stall_stats: got %0d (%b) expected %0d (%b)",
                     stall_cycles, out_vec, exp_stats, V_IDLE);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch();
        test_mdu_window();
        test_back_to_back();
        test_reset_mid_window();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1);
    end

endmodule
